// File: rtl/heading_pid.sv
// Heading PID steering controller: saturated error drives P, I and D terms,
// and the summed correction is split onto left/right wheel-speed commands.
module heading_pid #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [11:0] error,
    input  logic               err_vld,
    input  logic        [9:0]  frwrd,
    input  logic               moving,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rght_spd
);

    // Clamp a 13-bit signed wheel-speed sum into the 11-bit signed range.
    function automatic logic [10:0] sat11(input logic [12:0] v);
        if (!v[12] && (v[11:10] != 2'b00)) return 11'h3FF;
        if (v[12] && (v[11:10] != 2'b11))  return 11'h400;
        return v[10:0];
    endfunction

    logic [13:0] p_q, p_d;
    logic [13:0] d_q, d_d;
    logic [9:0]  prev_err_q, prev_err_d;
    logic [14:0] integ_q, integ_d;
    logic [10:0] lft_q, lft_d;
    logic [10:0] rght_q, rght_d;

    logic [9:0]  err_sat;
    logic [13:0] p_term;
    logic [10:0] diff;
    logic [6:0]  diff_sat;
    logic [13:0] d_term;
    logic [14:0] incr;
    logic [14:0] integ_sum;
    logic        integ_ovf;
    logic [13:0] i_term;
    logic [13:0] pid_sum;
    logic [12:0] pid;
    logic [12:0] lft_raw;
    logic [12:0] rght_raw;

    // NOTE: every combinational output gets a value on every path (defaults
    // first below) so no latches are inferred.
    always_comb begin
        if (!error[11] && (error[10:9] != 2'b00))
            err_sat = 10'h1FF;
        else if (error[11] && (error[10:9] != 2'b11))
            err_sat = 10'h200;
        else
            err_sat = error[9:0];

        p_term = {{4{err_sat[9]}}, err_sat} + {{3{err_sat[9]}}, err_sat, 1'b0};

        diff = {err_sat[9], err_sat} - {prev_err_q[9], prev_err_q};
        if (!diff[10] && (diff[9:6] != 4'h0))
            diff_sat = 7'h3F;
        else if (diff[10] && (diff[9:6] != 4'hF))
            diff_sat = 7'h40;
        else
            diff_sat = diff[6:0];
        d_term = {{7{diff_sat[6]}}, diff_sat} + {{5{diff_sat[6]}}, diff_sat, 2'b00};

        incr = FAST_SIM ? {{5{err_sat[9]}}, err_sat} : {{9{err_sat[9]}}, err_sat[9:4]};
        integ_sum = integ_q + incr;
        // Same-signed operands whose sum flips sign mean the integrator would wrap.
        integ_ovf = (incr[14] == integ_q[14]) && (integ_sum[14] != integ_q[14]);

        i_term  = {{5{integ_q[14]}}, integ_q[14:6]};
        pid_sum = p_q + i_term + d_q;
        pid     = {{2{pid_sum[13]}}, pid_sum[13:3]};

        lft_raw  = {3'b000, frwrd} + pid;
        rght_raw = {3'b000, frwrd} - pid;
    end

    always_comb begin
        p_d        = p_q;
        d_d        = d_q;
        prev_err_d = prev_err_q;
        integ_d    = integ_q;

        if (err_vld) begin
            p_d        = p_term;
            d_d        = d_term;
            prev_err_d = err_sat;
            if (moving && !integ_ovf)
                integ_d = integ_sum;
        end
        if (!moving)
            integ_d = '0;

        lft_d  = moving ? sat11(lft_raw)  : '0;
        rght_d = moving ? sat11(rght_raw) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= '0;
            d_q        <= '0;
            prev_err_q <= '0;
            integ_q    <= '0;
            lft_q      <= '0;
            rght_q     <= '0;
        end else begin
            p_q        <= p_d;
            d_q        <= d_d;
            prev_err_q <= prev_err_d;
            integ_q    <= integ_d;
            lft_q      <= lft_d;
            rght_q     <= rght_d;
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;

endmodule

// File: tb/tb_heading_pid.sv
// Self-checking bench for heading_pid: an integer reference model pushes the
// expected wheel speeds each edge and a checker pops and compares them.
module tb_heading_pid;

    logic               clk;
    logic               rst_n;
    logic signed [11:0] error;
    logic               err_vld;
    logic        [9:0]  frwrd;
    logic               moving;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;

    int n_checks;
    int n_fail;

    int exp_lft_q[$];
    int exp_rght_q[$];

    int m_p, m_d, m_prev, m_integ;

    heading_pid #(.FAST_SIM(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .error    (error),
        .err_vld  (err_vld),
        .frwrd    (frwrd),
        .moving   (moving),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference model: arithmetic on plain integers, one step per rising edge.
    always @(posedge clk or negedge rst_n) begin
        int es, pid, el, er, ns;
        if (!rst_n) begin
            m_p = 0; m_d = 0; m_prev = 0; m_integ = 0;
            exp_lft_q.delete();
            exp_rght_q.delete();
        end else begin
            es  = sat(int'(error), -512, 511);
            pid = (m_p + (m_integ >>> 6) + m_d) >>> 3;
            el  = moving ? sat(int'(frwrd) + pid, -1024, 1023) : 0;
            er  = moving ? sat(int'(frwrd) - pid, -1024, 1023) : 0;
            if (err_vld) begin
                m_p = es * 3;
                m_d = sat(es - m_prev, -64, 63) * 5;
                if (moving) begin
                    ns = m_integ + es;
                    if (ns >= -16384 && ns <= 16383) m_integ = ns;
                end
                m_prev = es;
            end
            if (!moving) m_integ = 0;
            exp_lft_q.push_back(el);
            exp_rght_q.push_back(er);
        end
    end

    always @(posedge clk) begin
        int el, er;
        #1;
        if (exp_lft_q.size() > 0) begin
            el = exp_lft_q.pop_front();
            er = exp_rght_q.pop_front();
            check("sb_lft", int'(lft_spd), el);
            check("sb_rght", int'(rght_spd), er);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_integ", int'($signed(dut.integ_q)), 0);
        check("rst_prev", int'($signed(dut.prev_err_q)), 0);
        check("rst_p", int'($signed(dut.p_q)), 0);
        check("rst_d", int'($signed(dut.d_q)), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input logic [11:0] e);
        @(negedge clk);
        error   = e;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        error    = '0;
        err_vld  = 1'b0;
        frwrd    = '0;
        moving   = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        check("init_lft", int'(lft_spd), 0);
        check("init_rght", int'(rght_spd), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        moving = 1'b1;
        frwrd  = 10'h100;

        pulse(12'h000);
        check("zero_err_lft", int'(lft_spd), 256);
        check("zero_err_rght", int'(rght_spd), 256);

        pulse(12'h7FF);
        check("pos_sat_lft", int'(lft_spd), 487);
        check("pos_sat_rght", int'(rght_spd), 25);

        do_reset();
        frwrd = 10'h3FF;
        pulse(12'h7FF);
        check("clamp_lft", int'(lft_spd), 1023);
        check("clamp_rght", int'(rght_spd), 792);

        do_reset();
        frwrd = 10'h000;
        pulse(12'h800);
        check("neg_sat_lft", int'(lft_spd), -233);
        check("neg_sat_rght", int'(rght_spd), 233);

        do_reset();
        pulse(12'hFFF);
        check("floor_lft", int'(lft_spd), -2);
        check("floor_rght", int'(rght_spd), 2);

        do_reset();
        frwrd = 10'h100;
        for (int i = 0; i < 40; i++) begin
            pulse(12'd511);
            if (i == 31) check("integ_32", int'($signed(dut.integ_q)), 16352);
        end
        check("integ_40", int'($signed(dut.integ_q)), 16352);
        check("integ_hold_lft", int'(lft_spd), 479);
        check("integ_hold_rght", int'(rght_spd), 33);

        @(negedge clk);
        moving = 1'b0;
        @(posedge clk);
        #1;
        check("stop_integ", int'($signed(dut.integ_q)), 0);
        check("stop_lft", int'(lft_spd), 0);
        check("stop_rght", int'(rght_spd), 0);

        @(negedge clk);
        moving = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            error   = (i % 2 == 0) ? 12'sd100 : -12'sd100;
            err_vld = 1'b1;
            @(posedge clk);
            #1;
            if (i > 0) check("alt_d", int'($signed(dut.d_q)), (i % 2 == 0) ? 315 : -320);
        end
        @(negedge clk);
        err_vld = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
